// File: rtl/ext_mem_pkg.sv
// Shared types and timing helpers for the external async-memory controller.
package ext_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TURN,
      SETUP,
      PULSE,
      HOLD
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   function automatic int state_cycles(
      input state_e st,
      input int     s,
      input int     p,
      input int     h,
      input int     t
   );
      int n;
      n = 0;
      unique case (st)
         TURN:    n = t;
         SETUP:   n = s;
         PULSE:   n = p;
         HOLD:    n = h;
         default: n = 0;
      endcase
      return n;
   endfunction

   function automatic int max4(
      input int a,
      input int b,
      input int c,
      input int d
   );
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/ext_mem_wait_cnt.sv
// Loadable down-counter that times each controller state.
module ext_mem_wait_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ext_sram_ctrl.sv
// External SRAM/flash bus controller: req/rdy handshake to timed
// CE/WE/OE/BE strobes with a tri-state data bus.
module ext_sram_ctrl
   import ext_mem_pkg::*;
#(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 32,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1,
   parameter int TURN_CYC  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic                wr,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   output logic                rdy,
   output logic                done,
   output logic [DATA_W-1:0]   rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_dq_o,
   output logic                mem_dq_oe,
   input  logic [DATA_W-1:0]   mem_dq_i,
   output logic                mem_ce_n,
   output logic                mem_we_n,
   output logic                mem_oe_n,
   output logic [DATA_W/8-1:0] mem_be_n
);

   localparam int BW   = DATA_W / 8;
   localparam int MAXC = max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, TURN_CYC);
   localparam int CW   = $clog2(MAXC + 1);

   if (DATA_W % 8 != 0) begin : g_bad_dw
      $error("ext_sram_ctrl: DATA_W must be a multiple of 8");
   end
   if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cyc
      $error("ext_sram_ctrl: SETUP/PULSE/HOLD cycles must be >= 1");
   end

   state_e              state_q, state_d;
   op_e                 op_q, prev_q, op_c;
   logic [ADDR_W-1:0]   addr_q, addr_c;
   logic [DATA_W-1:0]   wdata_q, wdata_c;
   logic [BW-1:0]       be_q, be_c;
   logic [DATA_W-1:0]   rdata_q, rmask;
   logic                done_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_dq_o_q;
   logic                mem_dq_oe_q;
   logic                mem_ce_n_q, mem_we_n_q, mem_oe_n_q;
   logic [BW-1:0]       mem_be_n_q;
   logic                accept, cnt_zero, cnt_load;
   logic [CW-1:0]       cnt_val;
   logic                fin, rd_cap;

   assign rdy    = (state_q == IDLE) && !rst;
   assign accept = req && rdy;

   // Accepted request fields are used directly on the acceptance edge.
   assign op_c    = accept ? op_e'(wr) : op_q;
   assign addr_c  = accept ? addr  : addr_q;
   assign wdata_c = accept ? wdata : wdata_q;
   assign be_c    = accept ? be    : be_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (wr && prev_q == OP_RD && TURN_CYC > 0) state_d = TURN;
               else state_d = SETUP;
            end
         end
         TURN:    if (cnt_zero) state_d = SETUP;
         SETUP:   if (cnt_zero) state_d = PULSE;
         PULSE:   if (cnt_zero) state_d = HOLD;
         HOLD:    if (cnt_zero) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      int cyc;
      cyc      = state_cycles(state_d, SETUP_CYC, PULSE_CYC, HOLD_CYC, TURN_CYC);
      cnt_load = (state_d != state_q);
      cnt_val  = (cyc > 0) ? CW'(cyc - 1) : '0;
   end

   always_comb begin
      rmask = '0;
      for (int i = 0; i < BW; i++) rmask[i*8 +: 8] = {8{be_q[i]}};
   end

   assign fin    = (state_q == HOLD) && (state_d == IDLE);
   assign rd_cap = (state_q == PULSE) && (state_d == HOLD) && (op_q == OP_RD);

   ext_mem_wait_cnt #(.W(CW)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= OP_WR;
         prev_q      <= OP_WR;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_dq_o_q  <= '0;
         mem_dq_oe_q <= 1'b0;
         mem_ce_n_q  <= 1'b1;
         mem_we_n_q  <= 1'b1;
         mem_oe_n_q  <= 1'b1;
         mem_be_n_q  <= '1;
      end else begin
         state_q <= state_d;
         done_q  <= fin;
         if (accept) begin
            op_q    <= op_e'(wr);
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
         end
         if (fin) prev_q <= op_q;
         if (rd_cap) rdata_q <= mem_dq_i & rmask;
         // Pins are set from the state being entered so they are registered.
         unique case (state_d)
            SETUP: begin
               mem_ce_n_q  <= 1'b0;
               mem_we_n_q  <= 1'b1;
               mem_oe_n_q  <= (op_c == OP_WR);
               mem_addr_q  <= addr_c;
               mem_be_n_q  <= ~be_c;
               mem_dq_oe_q <= (op_c == OP_WR);
               if (op_c == OP_WR) mem_dq_o_q <= wdata_c;
            end
            PULSE: begin
               mem_we_n_q <= (op_q != OP_WR);
               mem_oe_n_q <= (op_q == OP_WR);
            end
            HOLD: begin
               mem_we_n_q <= 1'b1;
               mem_oe_n_q <= 1'b1;
            end
            default: begin
               mem_ce_n_q  <= 1'b1;
               mem_we_n_q  <= 1'b1;
               mem_oe_n_q  <= 1'b1;
               mem_be_n_q  <= '1;
               mem_dq_oe_q <= 1'b0;
            end
         endcase
      end
   end

   assign done      = done_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_dq_o  = mem_dq_o_q;
   assign mem_dq_oe = mem_dq_oe_q;
   assign mem_ce_n  = mem_ce_n_q;
   assign mem_we_n  = mem_we_n_q;
   assign mem_oe_n  = mem_oe_n_q;
   assign mem_be_n  = mem_be_n_q;

endmodule
